// File: rtl/bm_pingpong_write_ctrl.sv
// Ping-pong write sequencer for the block-match bit-pixel RAM.
// Optional stall counter enabled by BM_PINGPONG_PERF_EN.
module bm_pingpong_write_ctrl #(
  parameter int WORDS_PER_STREAM = 8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_sel,
  input  logic [15:0] in_data,
  output logic [18:0] wr_address,
  output logic        write,
  output logic [15:0] wr_data,
  output logic        match_start,
  output logic        match_half,
  input  logic        match_done,
  output logic        wr_half,
  output logic        err_sel,
  output logic        err_done,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    BUSY
  } hstate_e;

  // One extra bit so a counter can hold the full count of 8192
  localparam logic [13:0] W = 14'(WORDS_PER_STREAM);

  hstate_e     st_q [2];
  hstate_e     st_d [2];
  logic [13:0] cnt_q [3];
  logic [13:0] cnt_d [3];
  logic        wr_half_q, wr_half_d;
  logic        write_q, write_d;
  logic [18:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        start_q, start_d;
  logic        mhalf_q, mhalf_d;
  logic        err_sel_q, err_sel_d;
  logic        err_done_q, err_done_d;
  logic [13:0] sel_cnt;
  logic        accept;
  logic        oth;

  always_comb begin
    sel_cnt = '0;
    case (in_sel)
      2'd0:    sel_cnt = cnt_q[0];
      2'd1:    sel_cnt = cnt_q[1];
      2'd2:    sel_cnt = cnt_q[2];
      default: sel_cnt = '0;
    endcase
  end

  assign in_ready = !reset
                  && (st_q[wr_half_q] == FILLING)
                  && ((in_sel == 2'd3) || (sel_cnt < W));
  assign accept = in_valid && in_ready;
  assign oth    = ~wr_half_q;

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    wr_half_d  = wr_half_q;
    write_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    start_d    = 1'b0;
    mhalf_d    = mhalf_q;
    err_sel_d  = err_sel_q;
    err_done_d = err_done_q;

    if (match_done) begin
      if (st_q[0] == BUSY)      st_d[0] = EMPTY;
      else if (st_q[1] == BUSY) st_d[1] = EMPTY;
      else                      err_done_d = 1'b1;
    end

    // The half only turns BUSY in the start cycle itself
    if (start_q) st_d[mhalf_q] = BUSY;

    if (accept) begin
      if (in_sel == 2'd3) begin
        err_sel_d = 1'b1;
      end else begin
        write_d = 1'b1;
        addr_d  = {wr_half_q, in_sel, 3'b000, sel_cnt[12:0]};
        data_d  = in_data;
        for (int b = 0; b < 3; b++) begin
          if (in_sel == 2'(b)) cnt_d[b] = cnt_q[b] + 14'd1;
        end
      end
    end

    if (cnt_d[0] == W && cnt_d[1] == W && cnt_d[2] == W) begin
      st_d[wr_half_q] = FULL;
      for (int b = 0; b < 3; b++) cnt_d[b] = '0;
    end

    if (st_d[0] != FILLING && st_d[1] != FILLING) begin
      if (st_d[wr_half_q] == EMPTY) begin
        st_d[wr_half_q] = FILLING;
      end else if (st_d[oth] == EMPTY) begin
        st_d[oth] = FILLING;
        wr_half_d = oth;
      end
    end

    if (!start_q && st_q[0] != BUSY && st_q[1] != BUSY) begin
      if (st_q[0] == FULL && st_q[1] == FULL) begin
        start_d = 1'b1;
        mhalf_d = ~mhalf_q;
      end else if (st_q[0] == FULL) begin
        start_d = 1'b1;
        mhalf_d = 1'b0;
      end else if (st_q[1] == FULL) begin
        start_d = 1'b1;
        mhalf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q[0]    <= EMPTY;
      st_q[1]    <= EMPTY;
      for (int b = 0; b < 3; b++) cnt_q[b] <= '0;
      wr_half_q  <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      start_q    <= 1'b0;
      mhalf_q    <= 1'b0;
      err_sel_q  <= 1'b0;
      err_done_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      wr_half_q  <= wr_half_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      start_q    <= start_d;
      mhalf_q    <= mhalf_d;
      err_sel_q  <= err_sel_d;
      err_done_q <= err_done_d;
    end
  end

  assign wr_address  = addr_q;
  assign write       = write_q;
  assign wr_data     = data_q;
  assign match_start = start_q;
  assign match_half  = mhalf_q;
  assign wr_half     = wr_half_q;
  assign err_sel     = err_sel_q;
  assign err_done    = err_done_q;

`ifdef BM_PINGPONG_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_bm_pingpong_write_ctrl.sv
// Randomized bench for bm_pingpong_write_ctrl against a
// transaction-level model of halves, pending queue and matcher.
module tb_bm_pingpong_write_ctrl;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_sel = '0;
  logic [15:0] in_data = '0;
  logic        match_done = 1'b0;
  logic        in_ready;
  logic [18:0] wr_address;
  logic        write;
  logic [15:0] wr_data;
  logic        match_start;
  logic        match_half;
  logic        wr_half;
  logic        err_sel;
  logic        err_done;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  bm_pingpong_write_ctrl #(.WORDS_PER_STREAM(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sel       (in_sel),
    .in_data      (in_data),
    .wr_address   (wr_address),
    .write        (write),
    .wr_data      (wr_data),
    .match_start  (match_start),
    .match_half   (match_half),
    .match_done   (match_done),
    .wr_half      (wr_half),
    .err_sel      (err_sel),
    .err_done     (err_done),
    .stall_cycles (stall_cycles)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: a half is free unless it is filling, queued, starting or busy
  bit          m_filling, m_whalf;
  int          m_cnt [3];
  bit          m_pend [$];
  bit          m_busy, m_bhalf;
  bit          m_start, m_shalf;
  bit          m_write;
  logic [18:0] m_addr;
  logic [15:0] m_data;
  bit          m_err_sel, m_err_done;
  int          m_stall;
  int          n_starts;

  function automatic bit occ(input bit h);
    foreach (m_pend[i]) if (m_pend[i] == h) return 1'b1;
    if (m_start && m_shalf == h) return 1'b1;
    if (m_busy && m_bhalf == h) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready(input logic [1:0] s);
    if (!m_filling) return 1'b0;
    if (s == 2'd3) return 1'b1;
    return m_cnt[s] < W;
  endfunction

  task automatic model_step(input bit v, input logic [1:0] s,
                            input logic [15:0] d, input bit dn,
                            input bit rs, input bit rdy);
    bit pre_busy, pre_start;
    int pre_pend;
    if (rs) begin
      m_filling = 0; m_whalf = 0; m_cnt = '{0, 0, 0};
      m_pend.delete(); m_busy = 0; m_bhalf = 0;
      m_start = 0; m_shalf = 0; m_write = 0;
      m_addr = '0; m_data = '0; m_err_sel = 0;
      m_err_done = 0; m_stall = 0;
      return;
    end
    if (v && !rdy && m_stall < 16'hFFFF) m_stall++;
    pre_busy  = m_busy;
    pre_start = m_start;
    pre_pend  = m_pend.size();
    if (dn) begin
      if (m_busy) m_busy = 0;
      else m_err_done = 1;
    end
    if (m_start) begin
      m_busy = 1;
      m_bhalf = m_shalf;
      m_start = 0;
    end
    m_write = 0;
    if (v && rdy) begin
      if (s == 2'd3) m_err_sel = 1;
      else begin
        m_write = 1;
        m_addr = {m_whalf, s, 3'b000, 13'(m_cnt[s])};
        m_data = d;
        m_cnt[s]++;
      end
    end
    if (m_cnt[0] == W && m_cnt[1] == W && m_cnt[2] == W) begin
      m_pend.push_back(m_whalf);
      m_filling = 0;
      m_cnt = '{0, 0, 0};
    end
    if (!pre_busy && !pre_start && pre_pend > 0) begin
      m_start = 1;
      m_shalf = m_pend.pop_front();
      n_starts++;
    end
    if (!m_filling) begin
      if (!occ(m_whalf)) m_filling = 1;
      else if (!occ(!m_whalf)) begin
        m_whalf = !m_whalf;
        m_filling = 1;
      end
    end
  endtask

  task automatic tick(input bit v, input logic [1:0] s,
                      input logic [15:0] d, input bit dn,
                      input bit rs, output bit acc);
    bit rdy;
    @(negedge clk);
    in_valid = v; in_sel = s; in_data = d;
    match_done = dn; reset = rs;
    #1;
    rdy = rs ? 1'b0 : m_ready(s);
    if (chk_en) begin
      check("in_ready", in_ready, rdy);
      check("write", write, m_write);
      if (m_write) begin
        check("wr_address", wr_address, m_addr);
        check("wr_data", wr_data, m_data);
      end
      check("match_start", match_start, m_start);
      check("match_half", match_half, m_shalf);
      check("wr_half", wr_half, m_whalf);
      check("err_sel", err_sel, m_err_sel);
      check("err_done", err_done, m_err_done);
`ifdef BM_PINGPONG_PERF_EN
      check("stall_cycles", stall_cycles, m_stall);
`else
      check("stall_cycles", stall_cycles, 0);
`endif
    end
    acc = v && rdy;
    model_step(v, s, d, dn, rs, rdy);
  endtask

  task automatic send(input logic [1:0] s, input logic [15:0] d,
                      input bit dn);
    bit acc;
    for (int n = 0; n < 40; n++) begin
      tick(1'b1, s, d, dn, 1'b0, acc);
      if (acc) return;
    end
    check("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    bit acc;
    tick(1'b0, 2'd0, 16'h0, 1'b0, 1'b1, acc);
    tick(1'b0, 2'd0, 16'h0, 1'b0, 1'b1, acc);
    check("rst_addr", wr_address, 0);
    check("rst_data", wr_data, 0);
  endtask

  initial begin
    bit acc;
    bit cv, cd;
    logic [1:0] cs;
    logic [15:0] cdat;
    int starts0;

    tick(1'b0, 2'd0, 16'h0, 1'b0, 1'b1, acc);
    chk_en = 1;
    do_reset();

    // two interleaved halves, then stall until a done frees half 0
    for (int i = 0; i < 24; i++) send(2'(i % 3), 16'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1, 2'd0, 16'h1234, 1'b0, 1'b0, acc);
    check("stalled_full", acc, 0);
    starts0 = n_starts;
    tick(1'b0, 2'd0, 16'h0, 1'b1, 1'b0, acc);
    for (int i = 0; i < 11; i++) send(2'(i % 3), 16'($urandom), 1'b0);
    check("second_start", n_starts, starts0 + 1);
    // last word of half 0 arrives with done freeing half 1
    tick(1'b1, 2'd2, 16'hBEEF, 1'b1, 1'b0, acc);
    check("last_word_acc", acc, 1);
    for (int i = 0; i < 4; i++) tick(1'b0, 2'd0, 16'h0, 1'b0, 1'b0, acc);

    // per-bank limit, illegal sel, spurious done, reset mid-fill
    do_reset();
    for (int i = 0; i < 4; i++) send(2'd0, 16'(i + 16'h100), 1'b0);
    tick(1'b1, 2'd0, 16'h5555, 1'b0, 1'b0, acc);
    check("sel0_full", acc, 0);
    tick(1'b1, 2'd1, 16'h6666, 1'b0, 1'b0, acc);
    check("sel1_acc", acc, 1);
    send(2'd3, 16'hDEAD, 1'b0);
    tick(1'b0, 2'd0, 16'h0, 1'b1, 1'b0, acc);
    for (int i = 0; i < 3; i++) tick(1'b0, 2'd0, 16'h0, 1'b0, 1'b0, acc);
    do_reset();
    send(2'd0, 16'hAAAA, 1'b0);
    tick(1'b0, 2'd0, 16'h0, 1'b1, 1'b0, acc);
    tick(1'b0, 2'd0, 16'h0, 1'b0, 1'b0, acc);

    // randomized traffic with random matcher latency and rare resets
    cv = 0; cs = 0; cdat = 0; acc = 0;
    for (int n = 0; n < 4000; n++) begin
      if (!(cv && !acc)) begin
        cv = ($urandom % 4) != 0;
        cs = (($urandom % 16) == 0) ? 2'd3 : 2'($urandom % 3);
        cdat = 16'($urandom);
      end
      if (m_busy) cd = ($urandom % 6) == 0;
      else cd = ($urandom % 80) == 0;
      if (($urandom % 600) == 0) begin
        tick(cv, cs, cdat, cd, 1'b1, acc);
        cv = 0;
      end else begin
        tick(cv, cs, cdat, cd, 1'b0, acc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
